mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM-state load/store unit of the multicycle core; consumer end of the execute stage.
//  Takes the ALU address and the store data, and runs one req/ack transaction on the data bus.
//  Builds byte lanes and enables for stores; extracts and sign/zero-extends load data.
//  Reports completion (done) back to the control FSM, plus a fault for misalignment/bus timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles bus_req may wait for bus_ack; 0 = never time out
// PORTS
//  clk         in   1   core clock; single clock domain
//  rst         in   1   reset, asynchronous, active-low
//  start       in   1   1-cycle pulse from control on entry to MEM state
//  mem_write   in   1   1 = store, 0 = load
//  ext_ctrl    in   3   funct3 size: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr        in   32  byte address (alu_result)
//  store_data  in   32  store value; low byte/half/word used per ext_ctrl
//  busy        out  1   high from cycle after start until done cycle inclusive
//  done        out  1   1-cycle pulse: access finished (with or without fault)
//  fault       out  1   valid with done: 1 = misaligned or timed out
//  load_data   out  32  extended load result; valid from done, held until next load done
//  bus_req     out  1   transaction request; held until bus_ack or timeout
//  bus_we      out  1   1 = write
//  bus_addr    out  32  word address {addr[31:2],2'b00}
//  bus_be      out  4   byte enables
//  bus_wdata   out  32  lane-replicated write data
//  bus_ack     in   1   completes the request in the cycle it is sampled with bus_req high
//  bus_rdata   in   32  read word, valid when bus_ack high
// BEHAVIOUR
//  Reset (rst low, async): state IDLE, timeout counter 0, all outputs 0, load_data 0.
//  FSM states: IDLE, REQ, RESP.
//  IDLE:
//   - start=1, aligned: latch addr/size/we/data, go to REQ.
//   - start=1, misaligned: go to RESP with fault; bus untouched.
//     Misaligned = h/hu with addr[0]=1, or w with addr[1:0]!=0.
//   - start outside IDLE is ignored.
//  REQ:
//   - bus_req=1; bus_we/addr/be/wdata stable throughout REQ.
//   - bus_ack=1: go to RESP, fault=0.
//   - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ack: go to RESP, fault=1.
//   - ack in the expiry cycle wins (fault=0).
//  RESP: done=1, fault as latched; return to IDLE. The next start is accepted the following cycle.
//  Latency:
//   - start at cycle 0: bus_req at cycle 1.
//   - ack at cycle k: done at cycle k+1. Zero-wait ack gives done at cycle 2.
//   - Misaligned: done+fault at cycle 1, no bus_req.
//  Enables (o = addr[1:0]): b/bu 4'b0001<<o; h/hu 4'b0011<<o; w 4'b1111. Loads drive the same be.
//  wdata: b {4{sd[7:0]}}; h {2{sd[15:0]}}; w sd.
//  Load extract: lane = bus_rdata >> (8*o).
//   - b/h sign-extend bit 7/15; bu/hu zero-extend; w as-is.
//   - Registered into load_data on ack.
//  load_data is not updated by stores, faulted accesses or timeouts.
//  Undefined ext_ctrl (011, 11x): treated as w.
//  Timeout counter clears on REQ entry. It saturates and never wraps.
//  Reset mid-REQ: bus_req drops asynchronously, no done pulse, transaction abandoned.
// TESTING
//  1. sb addr=0x103, sd=0x000000A5, ack at cycle 1 -> bus_be=1000, wdata=A5A5A5A5, addr=0x100; done cycle 2.
//  2. lb addr=0x201, rdata=0x1234_80FF -> load_data=0xFFFFFF80; lbu same -> 0x00000080.
//  3. lh addr=0x203 -> done+fault at cycle 1, bus_req never asserted, load_data unchanged.
//  4. lw, TIMEOUT_CYCLES=4, no ack -> bus_req high cycles 1-4, done+fault cycle 5.
//     Repeat with ack in cycle 4 -> fault=0.
//  5. sw with ack after 3 wait cycles; bus_addr/be/wdata held stable.
//     A second start pulse mid-REQ is ignored.
//  6. rst low while bus_req=1 -> bus_req=0 same cycle, busy=0, no done. A post-reset lw completes normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage load/store unit: one req/ack data-bus transaction per start pulse,
// with store lane/enable generation, load extraction and misalign/timeout fault.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_write,
    input  logic [2:0]  ext_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    size_t       size_in, size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic        fault_q;
    logic [CW-1:0] cnt;
    logic        misaligned;
    logic        timed_out;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_value;

    // funct3 bit 1 set (010, 011, 11x) means word; undefined codes fall in here.
    always_comb begin
        size_in = ext_ctrl[1] ? SZ_W : (ext_ctrl[0] ? SZ_H : SZ_B);
        misaligned = ((size_in == SZ_H) && addr[0]) ||
                     ((size_in == SZ_W) && (addr[1:0] != 2'b00));
        case (size_in)
            SZ_B:    begin be_in = 4'b0001 << addr[1:0]; wdata_in = {4{store_data[7:0]}};  end
            SZ_H:    begin be_in = 4'b0011 << addr[1:0]; wdata_in = {2{store_data[15:0]}}; end
            default: begin be_in = 4'b1111;              wdata_in = store_data;            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_B:    ld_value = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    ld_value = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_value = bus_rdata;
        endcase
    end

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = misaligned ? RESP : REQ;
            REQ:     if (bus_ack || timed_out) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
        busy    = (state != IDLE);
        done    = (state == RESP);
        bus_req = (state == REQ);
        fault   = (state == RESP) && fault_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            off_q     <= '0;
            fault_q   <= 1'b0;
            cnt       <= '0;
            load_data <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    fault_q <= misaligned;
                    cnt     <= '0;
                    // A misaligned access never reaches the bus, so its fields stay unlatched.
                    if (!misaligned) begin
                        size_q    <= size_in;
                        uns_q     <= ext_ctrl[2];
                        off_q     <= addr[1:0];
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_in;
                        bus_wdata <= wdata_in;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        fault_q <= 1'b0;
                        if (!bus_we) load_data <= ld_value;
                    end else if (timed_out) begin
                        fault_q <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT_CYCLES=4): per-scenario tasks with
// hand-computed expectations and cycle-exact latency checks.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  ext_ctrl = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_write(mem_write),
        .ext_ctrl(ext_ctrl), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse during the current cycle (cycle 0); returns 1 ns into cycle 1.
    task automatic issue(input logic we, input logic [2:0] ext, input logic [31:0] a,
                         input logic [31:0] sd);
        start = 1'b1; mem_write = we; ext_ctrl = ext; addr = a; store_data = sd;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        checks++;
        if ({busy, done, fault, bus_req, bus_we} !== 5'b0 || load_data !== 32'h0 ||
            bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b fault=%b req=%b we=%b ld=%h addr=%h be=%b wd=%h want all 0",
                     busy, done, fault, bus_req, bus_we, load_data, bus_addr, bus_be, bus_wdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_store_byte();
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b1000 ||
            bus_wdata !== 32'hA5A5_A5A5 || bus_addr !== 32'h0000_0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus: req=%b we=%b be=%b wd=%h addr=%h busy=%b want 1 1 1000 a5a5a5a5 00000100 1",
                     bus_req, bus_we, bus_be, bus_wdata, bus_addr, busy);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_done: done=%b fault=%b req=%b busy=%b want 1 0 0 1", done, fault, bus_req, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  ext [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] a   [5]  = '{32'h201, 32'h201, 32'h202, 32'h202, 32'h300};
        logic [31:0] rd  [5]  = '{32'h1234_80FF, 32'h1234_80FF, 32'h8000_1234, 32'h8000_1234, 32'hDEAD_BEEF};
        logic [3:0]  be  [5]  = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1111};
        logic [31:0] exp [5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000, 32'hDEAD_BEEF};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, ext[i], a[i], 32'hFFFF_FFFF);
            checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== be[i] || bus_addr !== {a[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_bus[%0d]: req=%b we=%b be=%b addr=%h want 1 0 %b %h",
                         i, bus_req, bus_we, bus_be, bus_addr, be[i], {a[i][31:2], 2'b00});
            end
            bus_ack = 1'b1; bus_rdata = rd[i];
            step();
            bus_ack = 1'b0; bus_rdata = 32'h0;
            checks++;
            if (done !== 1'b1 || fault !== 1'b0 || load_data !== exp[i]) begin
                errors++;
                $display("FAIL load_data[%0d]: done=%b fault=%b ld=%h want 1 0 %h", i, done, fault, load_data, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_misaligned();
        issue(1'b0, 3'b001, 32'h0000_0203, 32'h0);
        checks++;
        if (done !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0 || load_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL misalign_lh: done=%b fault=%b req=%b ld=%h want 1 1 0 deadbeef", done, fault, bus_req, load_data);
        end
        step();
        issue(1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222);
        checks++;
        if (done !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0 || bus_addr !== 32'h300 || bus_be !== 4'b1111) begin
            errors++;
            $display("FAIL misalign_sw: done=%b fault=%b req=%b addr=%h be=%b want 1 1 0 00000300 1111",
                     done, fault, bus_req, bus_addr, bus_be);
        end
        step();
    endtask

    task automatic test_timeout();
        int bad;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        bad = 0;
        for (int c = 1; c <= 4; c++) begin
            if (bus_req !== 1'b1 || done !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_req: %0d of cycles 1-4 wrong, want req=1 done=0 throughout", bad);
        end
        checks++;
        if (done !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0 || load_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL timeout_done: done=%b fault=%b req=%b ld=%h want 1 1 0 deadbeef", done, fault, bus_req, load_data);
        end
        step();
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        step(); step(); step();
        bus_ack = 1'b1; bus_rdata = 32'h55AA_00FF;
        step();
        bus_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'h55AA_00FF) begin
            errors++;
            $display("FAIL ack_at_expiry: done=%b fault=%b ld=%h want 1 0 55aa00ff", done, fault, load_data);
        end
        step();
    endtask

    task automatic test_store_wait();
        int bad;
        issue(1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344);
        bad = 0;
        for (int c = 1; c <= 4; c++) begin
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h40 ||
                bus_be !== 4'b1111 || bus_wdata !== 32'h1122_3344) bad++;
            if (c == 2) begin
                start = 1'b1; mem_write = 1'b0; ext_ctrl = 3'b000; addr = 32'h999; store_data = 32'h77;
            end else begin
                start = 1'b0;
            end
            bus_ack = (c == 4);
            step();
        end
        bus_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sw_stable: %0d of cycles 1-4 wrong, want req=1 we=1 addr=40 be=1111 wd=11223344", bad);
        end
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'h55AA_00FF) begin
            errors++;
            $display("FAIL sw_done: done=%b fault=%b ld=%h want 1 0 55aa00ff", done, fault, load_data);
        end
        step();
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL sw_midstart: busy=%b req=%b want 0 0", busy, bus_req);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'b001, 32'h0000_0082, 32'hABCD_5A6B);
        checks++;
        if (bus_be !== 4'b1100 || bus_wdata !== 32'h5A6B_5A6B || bus_addr !== 32'h80) begin
            errors++;
            $display("FAIL sh_bus: be=%b wd=%h addr=%h want 1100 5a6b5a6b 00000080", bus_be, bus_wdata, bus_addr);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        // Start while in the done cycle must be ignored.
        start = 1'b1; mem_write = 1'b0; ext_ctrl = 3'b010; addr = 32'h500;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL start_in_resp: busy=%b req=%b want 0 0", busy, bus_req);
        end
        issue(1'b0, 3'b110, 32'h0000_0504, 32'h0);
        checks++;
        if (bus_req !== 1'b1 || bus_be !== 4'b1111 || bus_addr !== 32'h504) begin
            errors++;
            $display("FAIL b2b_undef_w: req=%b be=%b addr=%h want 1 1111 00000504", bus_req, bus_be, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h8765_4321;
        step();
        bus_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || load_data !== 32'h8765_4321) begin
            errors++;
            $display("FAIL b2b_done: done=%b ld=%h want 1 87654321", done, load_data);
        end
        step();
    endtask

    task automatic test_reset_mid_req();
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: req=%b want 1", bus_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_req: req=%b busy=%b done=%b ld=%h want 0 0 0 0", bus_req, busy, done, load_data);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done=%b busy=%b want 0 0", done, busy);
        end
        issue(1'b0, 3'b010, 32'h0000_0080, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || load_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL post_rst_lw: done=%b fault=%b ld=%h want 1 0 cafef00d", done, fault, load_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_extend();
        test_misaligned();
        test_timeout();
        test_store_wait();
        test_back_to_back();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
